// File: rtl/pc_unit_pkg.sv
// Shared next-PC definitions for the fetch, hazard and PC logic.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        SRC_TRAP,
        SRC_REDIRECT,
        SRC_HOLD,
        SRC_RAS,
        SRC_SEQ
    } pc_src_e;

    localparam int         PC_INC_DEFAULT = 4;
    localparam logic [1:0] ALIGN_MASK     = 2'b11;

    function automatic logic is_aligned(input logic [1:0] lsbs);
        return (lsbs & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push beyond DEPTH overwrites the oldest entry.
module pc_ras
    import pc_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] top,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] entry [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;

    assign top   = entry[ptr];
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (replace) begin
            entry[ptr] <= wdata;
        end else if (push) begin
            ptr               <= ptr + 1'b1;
            entry[ptr + 1'b1] <= wdata;
            if (count != CNT_MAX) count <= count + 1'b1;
        end else if (pop && !empty) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Architectural PC register with trap/redirect/RAS/sequential next-PC selection.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4,
    parameter int               INC       = PC_INC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             trap_valid,
    input  logic [WIDTH-1:0] trap_vector,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call_valid,
    input  logic             ret_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             ras_empty,
    output logic             ras_underflow,
    output logic             target_misalign
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    pc_src_e          src;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_en;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_replace;
    logic             misalign_d;
    logic             underflow_d;

    assign pc_plus_inc = pc + INC_W;

    always_comb begin
        src = SRC_SEQ;
        if (trap_valid)
            src = SRC_TRAP;
        else if (redirect_valid && is_aligned(redirect_target[1:0]))
            src = SRC_REDIRECT;
        else if (redirect_valid || stall)
            src = SRC_HOLD;
        else if (ret_valid && !ras_empty)
            src = SRC_RAS;
    end

    always_comb begin
        next_pc = pc_plus_inc;
        unique case (src)
            SRC_TRAP:     next_pc = trap_vector;
            SRC_REDIRECT: next_pc = redirect_target;
            SRC_HOLD:     next_pc = pc;
            SRC_RAS:      next_pc = ras_top;
            SRC_SEQ:      next_pc = pc_plus_inc;
            default:      next_pc = pc_plus_inc;
        endcase
    end

    // Stack only moves when the instruction actually retires down the normal path.
    assign ras_en      = (src == SRC_RAS) || (src == SRC_SEQ);
    assign ras_replace = ras_en && call_valid && ret_valid && !ras_empty;
    assign ras_push    = ras_en && call_valid && !ras_replace;
    assign ras_pop     = ras_en && ret_valid && !call_valid && !ras_empty;
    assign underflow_d = ras_en && ret_valid && ras_empty;
    assign misalign_d  = !trap_valid && redirect_valid && !is_aligned(redirect_target[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_VEC;
            ras_underflow   <= 1'b0;
            target_misalign <= 1'b0;
        end else begin
            pc              <= next_pc;
            ras_underflow   <= underflow_d;
            target_misalign <= misalign_d;
        end
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (ras_push),
        .pop     (ras_pop),
        .replace (ras_replace),
        .wdata   (pc_plus_inc),
        .top     (ras_top),
        .empty   (ras_empty)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with RESET_VEC=0x100, RAS_DEPTH=4, INC=4.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        call_valid;
    logic        ret_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_inc;
    logic        ras_empty;
    logic        ras_underflow;
    logic        target_misalign;

    int checks   = 0;
    int failures = 0;

    pc_unit #(
        .WIDTH     (32),
        .RESET_VEC (32'h100),
        .RAS_DEPTH (4),
        .INC       (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call_valid      (call_valid),
        .ret_valid       (ret_valid),
        .pc              (pc),
        .pc_plus_inc     (pc_plus_inc),
        .ras_empty       (ras_empty),
        .ras_underflow   (ras_underflow),
        .target_misalign (target_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; trap_valid = 0; trap_vector = '0;
        redirect_valid = 0; redirect_target = '0;
        call_valid = 0; ret_valid = 0;
    endtask

    task automatic go_to(input logic [31:0] addr);
        idle_inputs();
        redirect_valid = 1; redirect_target = addr;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL reset_pc: got %h want %h", pc, 32'h100); end
        checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
        checks++; if (ras_underflow !== 1'b0 || target_misalign !== 1'b0) begin failures++; $display("FAIL reset_pulses: got %b%b want 00", ras_underflow, target_misalign); end
        checks++; if (pc_plus_inc !== 32'h104) begin failures++; $display("FAIL reset_plus_inc: got %h want %h", pc_plus_inc, 32'h104); end
        rst = 0;
        tick();
        checks++; if (pc !== 32'h104) begin failures++; $display("FAIL release_1: got %h want %h", pc, 32'h104); end
        tick();
        checks++; if (pc !== 32'h108) begin failures++; $display("FAIL release_2: got %h want %h", pc, 32'h108); end
    endtask

    task automatic test_stall_redirect();
        stall = 1;
        tick();
        checks++; if (pc !== 32'h108) begin failures++; $display("FAIL stall_hold: got %h want %h", pc, 32'h108); end
        redirect_valid = 1; redirect_target = 32'h200;
        tick();
        checks++; if (pc !== 32'h200) begin failures++; $display("FAIL stall_redirect: got %h want %h", pc, 32'h200); end
        idle_inputs();
    endtask

    task automatic test_trap_priority();
        trap_valid = 1; trap_vector = 32'h80;
        redirect_valid = 1; redirect_target = 32'h300;
        ret_valid = 1; call_valid = 1;
        tick();
        checks++; if (pc !== 32'h80) begin failures++; $display("FAIL trap_pc: got %h want %h", pc, 32'h80); end
        checks++; if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin failures++; $display("FAIL trap_ras: got empty=%b uf=%b want 1 0", ras_empty, ras_underflow); end
        idle_inputs();
    endtask

    task automatic test_call_ret();
        go_to(32'h10);
        call_valid = 1;
        tick();
        call_valid = 0;
        checks++; if (pc !== 32'h14 || ras_empty !== 1'b0) begin failures++; $display("FAIL call1: got pc=%h empty=%b want 14 0", pc, ras_empty); end
        go_to(32'h20);
        call_valid = 1;
        tick();
        call_valid = 0;
        tick();
        checks++; if (pc !== 32'h28) begin failures++; $display("FAIL call2_seq: got %h want %h", pc, 32'h28); end
        ret_valid = 1;
        tick();
        checks++; if (pc !== 32'h24) begin failures++; $display("FAIL ret1: got %h want %h", pc, 32'h24); end
        tick();
        checks++; if (pc !== 32'h14 || ras_empty !== 1'b1) begin failures++; $display("FAIL ret2: got pc=%h empty=%b want 14 1", pc, ras_empty); end
        checks++; if (ras_underflow !== 1'b0) begin failures++; $display("FAIL ret2_uf: got %b want 0", ras_underflow); end
        tick();
        checks++; if (pc !== 32'h18 || ras_underflow !== 1'b1) begin failures++; $display("FAIL ret3_underflow: got pc=%h uf=%b want 18 1", pc, ras_underflow); end
        ret_valid = 0;
        tick();
        checks++; if (pc !== 32'h1c || ras_underflow !== 1'b0) begin failures++; $display("FAIL underflow_clear: got pc=%h uf=%b want 1c 0", pc, ras_underflow); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [4];
        exp_ret = '{32'h1014, 32'h1010, 32'h100c, 32'h1008};
        go_to(32'h1000);
        call_valid = 1;
        for (int i = 0; i < 5; i++) tick();
        call_valid = 0;
        checks++; if (pc !== 32'h1014) begin failures++; $display("FAIL ovf_calls: got %h want %h", pc, 32'h1014); end
        go_to(32'h2000);
        ret_valid = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc !== exp_ret[i]) begin failures++; $display("FAIL ovf_ret%0d: got %h want %h", i, pc, exp_ret[i]); end
        end
        tick();
        checks++; if (pc !== 32'h100c || ras_underflow !== 1'b1) begin failures++; $display("FAIL ovf_ret5: got pc=%h uf=%b want 100c 1", pc, ras_underflow); end
        idle_inputs();
    endtask

    task automatic test_call_ret_same();
        go_to(32'h3000);
        call_valid = 1;
        tick();
        go_to(32'h3100);
        call_valid = 1; ret_valid = 1;
        tick();
        checks++; if (pc !== 32'h3004) begin failures++; $display("FAIL cr_same_pc: got %h want %h", pc, 32'h3004); end
        call_valid = 0;
        tick();
        checks++; if (pc !== 32'h3104 || ras_empty !== 1'b1) begin failures++; $display("FAIL cr_same_replaced: got pc=%h empty=%b want 3104 1", pc, ras_empty); end
        idle_inputs();
    endtask

    task automatic test_misalign();
        go_to(32'h40);
        redirect_valid = 1; redirect_target = 32'h202;
        tick();
        idle_inputs();
        checks++; if (pc !== 32'h40 || target_misalign !== 1'b1) begin failures++; $display("FAIL misalign: got pc=%h mis=%b want 40 1", pc, target_misalign); end
        tick();
        checks++; if (pc !== 32'h44 || target_misalign !== 1'b0) begin failures++; $display("FAIL misalign_clear: got pc=%h mis=%b want 44 0", pc, target_misalign); end
    endtask

    task automatic test_wrap();
        go_to(32'hffff_fffc);
        checks++; if (pc_plus_inc !== 32'h0) begin failures++; $display("FAIL wrap_plus_inc: got %h want 0", pc_plus_inc); end
        tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h want 0", pc); end
    endtask

    task automatic test_mid_reset();
        call_valid = 1;
        tick();
        rst = 1; trap_valid = 1; trap_vector = 32'h500; ret_valid = 1;
        tick();
        rst = 0;
        idle_inputs();
        checks++; if (pc !== 32'h100 || ras_empty !== 1'b1) begin failures++; $display("FAIL mid_reset: got pc=%h empty=%b want 100 1", pc, ras_empty); end
        ret_valid = 1;
        tick();
        ret_valid = 0;
        checks++; if (pc !== 32'h104 || ras_underflow !== 1'b1) begin failures++; $display("FAIL mid_reset_ras: got pc=%h uf=%b want 104 1", pc, ras_underflow); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_stall_redirect();
        test_trap_priority();
        test_call_ret();
        test_ras_overflow();
        test_call_ret_same();
        test_misalign();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
